// File: rtl/jtag_scan_master_if.sv
// Command/response handshake between a scan client and the JTAG scan engine.
// The client drives commands; the engine returns one captured TDO word per command.
interface jtag_scan_master_if #(
  parameter int DR_W = 40
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [1:0]      cmd_type;
  logic [DR_W-1:0] cmd_data;
  logic            rsp_valid;
  logic [DR_W-1:0] rsp_data;
  logic            busy;

  modport master (
    output cmd_valid, cmd_type, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  cmd_valid, cmd_type, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/jtag_scan_master.sv
// JTAG scan engine: turns reset / IR / DR / idle commands into TCK/TMS/TDI
// bit sequences for a TAP controller and returns the captured TDO word.
module jtag_scan_master #(
  parameter int IR_W       = 5,
  parameter int DR_W       = 40,
  parameter int CLK_DIV    = 4,
  parameter int TLR_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst,
  jtag_scan_master_if.slave bus,
  output logic              jtag_TCK,
  output logic              jtag_TMS,
  output logic              jtag_TDI,
  input  logic              jtag_TDO
);

  localparam int M1       = (TLR_CYCLES + 1 > IR_W + 6) ? TLR_CYCLES + 1 : IR_W + 6;
  localparam int M2       = (M1 > DR_W + 5) ? M1 : DR_W + 5;
  localparam int MAX_BITS = (M2 > 255) ? M2 : 255;
  localparam int CNT_W    = $clog2(MAX_BITS + 1);
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {
    CMD_RESET = 2'b00,
    CMD_IR    = 2'b01,
    CMD_DR    = 2'b10,
    CMD_IDLE  = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_RUN
  } state_e;

  state_e           state;
  cmd_e             cmd;
  logic [DR_W-1:0]  sr;
  logic [DR_W-1:0]  sr_shifted;
  logic [CNT_W-1:0] nbits;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] next_idx;
  logic [DIV_W-1:0] div_cnt;
  logic             cur_shift;
  logic             nxt_tms;
  logic             nxt_shift;

  assign bus.busy = ~bus.cmd_ready;

  // Index of the bit whose TMS/TDI get driven at the next bit boundary.
  assign next_idx = (state == S_START) ? '0 : bit_cnt + 1'b1;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    nxt_tms   = 1'b0;
    nxt_shift = 1'b0;
    case (cmd)
      CMD_RESET: nxt_tms = next_idx < CNT_W'(TLR_CYCLES);
      CMD_IR: begin
        nxt_shift = next_idx >= CNT_W'(4) && next_idx < CNT_W'(IR_W + 4);
        nxt_tms   = next_idx < CNT_W'(2) || next_idx == CNT_W'(IR_W + 3) ||
                    next_idx == CNT_W'(IR_W + 4);
      end
      CMD_DR: begin
        nxt_shift = next_idx >= CNT_W'(3) && next_idx < CNT_W'(DR_W + 3);
        nxt_tms   = next_idx == '0 || next_idx == CNT_W'(DR_W + 2) ||
                    next_idx == CNT_W'(DR_W + 3);
      end
      default: nxt_tms = 1'b0;
    endcase
  end

  // One register serves both directions: TDI leaves from bit 0, TDO enters at the top.
  always_comb begin
    sr_shifted = sr >> 1;
    if (cmd == CMD_IR) sr_shifted[IR_W-1] = jtag_TDO;
    else               sr_shifted[DR_W-1] = jtag_TDO;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= S_IDLE;
      cmd           <= CMD_RESET;
      sr            <= '0;
      nbits         <= '0;
      bit_cnt       <= '0;
      div_cnt       <= '0;
      cur_shift     <= 1'b0;
      bus.cmd_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      jtag_TCK      <= 1'b0;
      jtag_TMS      <= 1'b1;
      jtag_TDI      <= 1'b1;
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid && bus.cmd_ready) begin
            cmd           <= cmd_e'(bus.cmd_type);
            bus.cmd_ready <= 1'b0;
            bit_cnt       <= '0;
            div_cnt       <= '0;
            state         <= S_START;
            case (cmd_e'(bus.cmd_type))
              CMD_RESET: begin
                nbits <= CNT_W'(TLR_CYCLES + 1);
                sr    <= '0;
              end
              CMD_IR: begin
                nbits <= CNT_W'(IR_W + 6);
                sr    <= bus.cmd_data & DR_W'({IR_W{1'b1}});
              end
              CMD_DR: begin
                nbits <= CNT_W'(DR_W + 5);
                sr    <= bus.cmd_data;
              end
              default: begin
                nbits <= CNT_W'(bus.cmd_data[7:0]);
                sr    <= '0;
              end
            endcase
          end
        end

        S_START: begin
          if (nbits == '0) begin
            state         <= S_IDLE;
            bus.cmd_ready <= 1'b1;
            bus.rsp_valid <= 1'b1;
            bus.rsp_data  <= sr;
          end else begin
            jtag_TMS  <= nxt_tms;
            jtag_TDI  <= nxt_shift ? sr[0] : 1'b1;
            cur_shift <= nxt_shift;
            state     <= S_RUN;
          end
        end

        S_RUN: begin
          if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
            div_cnt <= '0;
            if (!jtag_TCK) begin
              // Last low cycle: TDO is stable, capture it as TCK rises.
              jtag_TCK <= 1'b1;
              if (cur_shift) sr <= sr_shifted;
            end else begin
              jtag_TCK <= 1'b0;
              if (bit_cnt == nbits - 1'b1) begin
                state         <= S_IDLE;
                bus.cmd_ready <= 1'b1;
                bus.rsp_valid <= 1'b1;
                bus.rsp_data  <= sr;
                jtag_TDI      <= 1'b1;
              end else begin
                bit_cnt   <= bit_cnt + 1'b1;
                jtag_TMS  <= nxt_tms;
                jtag_TDI  <= nxt_shift ? sr[0] : 1'b1;
                cur_shift <= nxt_shift;
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_scan_master.sv
// Bench for jtag_scan_master: drives commands into a behavioural TAP controller
// and scoreboards every response word against expectations pushed at accept time.
module tb_jtag_scan_master;

  localparam int IR_W = 5;
  localparam int DR_W = 40;
  localparam int CLK_DIV = 2;
  localparam int TLR_CYCLES = 8;
  localparam int LIM = 1000;
  localparam logic [DR_W-1:0] UREG_INIT = 40'hC3_5A96_F081;

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
  } tap_e;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic jtag_TCK, jtag_TMS, jtag_TDI;
  logic jtag_TDO = 1'b0;

  int checks = 0;
  int errors = 0;
  int rsp_cnt = 0;
  bit tms_log[$];
  bit tdi_log[$];
  logic [DR_W-1:0] exp_q[$];

  jtag_scan_master_if #(.DR_W(DR_W)) bus ();

  jtag_scan_master #(
    .IR_W(IR_W), .DR_W(DR_W), .CLK_DIV(CLK_DIV), .TLR_CYCLES(TLR_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .jtag_TCK(jtag_TCK), .jtag_TMS(jtag_TMS), .jtag_TDI(jtag_TDI), .jtag_TDO(jtag_TDO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural TAP: IR captures 00001, IR=all-ones selects BYPASS,
  // any other IR selects a 40-bit user register.
  tap_e            tap = TLR;
  logic [IR_W-1:0] ir = 5'h01;
  logic [IR_W-1:0] ir_sr = '0;
  logic [DR_W-1:0] dr_sr = '0;
  logic [DR_W-1:0] ureg = UREG_INIT;
  logic            byp = 1'b0;
  wire             bypass = (ir == {IR_W{1'b1}});

  function automatic tap_e tap_next(input tap_e s, input logic tms);
    case (s)
      TLR:     return tms ? TLR    : RTI;
      RTI:     return tms ? SEL_DR : RTI;
      SEL_DR:  return tms ? SEL_IR : CAP_DR;
      CAP_DR:  return tms ? EX1_DR : SH_DR;
      SH_DR:   return tms ? EX1_DR : SH_DR;
      EX1_DR:  return tms ? UPD_DR : PAU_DR;
      PAU_DR:  return tms ? EX2_DR : PAU_DR;
      EX2_DR:  return tms ? UPD_DR : SH_DR;
      UPD_DR:  return tms ? SEL_DR : RTI;
      SEL_IR:  return tms ? TLR    : CAP_IR;
      CAP_IR:  return tms ? EX1_IR : SH_IR;
      SH_IR:   return tms ? EX1_IR : SH_IR;
      EX1_IR:  return tms ? UPD_IR : PAU_IR;
      PAU_IR:  return tms ? EX2_IR : PAU_IR;
      EX2_IR:  return tms ? UPD_IR : SH_IR;
      default: return tms ? SEL_DR : RTI;
    endcase
  endfunction

  always @(posedge jtag_TCK) begin
    tms_log.push_back(jtag_TMS);
    tdi_log.push_back(jtag_TDI);
    case (tap)
      TLR:    ir <= 5'h01;
      CAP_IR: ir_sr <= 5'b00001;
      SH_IR:  ir_sr <= {jtag_TDI, ir_sr[IR_W-1:1]};
      CAP_DR: if (bypass) byp <= 1'b0; else dr_sr <= ureg;
      SH_DR:  if (bypass) byp <= jtag_TDI; else dr_sr <= {jtag_TDI, dr_sr[DR_W-1:1]};
      default: ;
    endcase
    tap <= tap_next(tap, jtag_TMS);
  end

  always @(negedge jtag_TCK) begin
    jtag_TDO <= (tap == SH_IR) ? ir_sr[0] :
                (tap == SH_DR) ? (bypass ? byp : dr_sr[0]) : 1'b0;
    if (tap == UPD_IR) ir <= ir_sr;
    if (tap == UPD_DR && !bypass) ureg <= dr_sr;
  end

  // Response scoreboard.
  always @(negedge clk) begin
    if (bus.rsp_valid) begin
      rsp_cnt++;
      if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
      else                   check("rsp_data", bus.rsp_data, exp_q.pop_front());
    end
  end

  function automatic logic [63:0] pack_tms();
    logic [63:0] v = '0;
    for (int i = 0; i < tms_log.size() && i < 64; i++) v[i] = tms_log[i];
    return v;
  endfunction

  function automatic logic [63:0] pack_tdi(input int from, input int n);
    logic [63:0] v = '0;
    for (int i = 0; i < n && from + i < tdi_log.size(); i++) v[i] = tdi_log[from + i];
    return v;
  endfunction

  task automatic wait_rsp(input string tag, input int exp_lat);
    bit got = 1'b0;
    int lat = 0;
    for (int i = 1; i <= LIM; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        lat = i;
        got = 1'b1;
        break;
      end
    end
    if (!got) check({tag, "_timeout"}, 0, 1);
    else begin
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_ready"}, bus.cmd_ready, 1);
    end
  endtask

  task automatic run_cmd(input string tag, input logic [1:0] t, input logic [DR_W-1:0] d,
                         input logic [DR_W-1:0] exp_rsp, input int exp_lat);
    @(negedge clk);
    tms_log.delete();
    tdi_log.delete();
    bus.cmd_valid = 1'b1;
    bus.cmd_type  = t;
    bus.cmd_data  = d;
    @(posedge clk);
    exp_q.push_back(exp_rsp);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check({tag, "_busy"}, bus.busy, 1);
    wait_rsp(tag, exp_lat);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0;
    bit hit;
    bus.cmd_valid = 1'b0;
    bus.cmd_type  = 2'b00;
    bus.cmd_data  = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", bus.cmd_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_tck", jtag_TCK, 0);
    check("rst_tms", jtag_TMS, 1);
    check("rst_tdi", jtag_TDI, 1);
    rst = 1'b1;

    run_cmd("tlr", 2'b00, 40'hA5_A5A5_A5A5, '0, 37);
    check("tlr_edges", tms_log.size(), 9);
    check("tlr_tms", pack_tms(), 64'hFF);
    check("tlr_tdi", pack_tdi(0, 9), 64'h1FF);
    check("tlr_tap", tap, RTI);

    run_cmd("ir", 2'b01, 40'hFF_FFFF_FF11, 40'h01, 45);
    check("ir_edges", tms_log.size(), 11);
    check("ir_tms", pack_tms(), 64'h303);
    check("ir_tdi_shift", pack_tdi(4, 5), 64'h11);
    check("ir_tdi_frame", {pack_tdi(0, 4), pack_tdi(9, 2)}, {64'hF, 64'h3});
    check("ir_model", ir, 5'h11);

    run_cmd("dr_user1", 2'b10, 40'h0F_1E2D_3C4B, UREG_INIT, 181);
    check("dr_user1_edges", tms_log.size(), 45);
    check("dr_user1_tms", pack_tms(), 64'h0000_0C00_0000_0001);
    check("dr_user1_tdi", pack_tdi(3, 40), 64'h0F_1E2D_3C4B);
    run_cmd("dr_user2", 2'b10, 40'h80_0000_0001, 40'h0F_1E2D_3C4B, 181);

    run_cmd("ir_byp", 2'b01, 40'h1F, 40'h01, 45);
    check("ir_byp_model", ir, 5'h1F);
    run_cmd("dr_byp", 2'b10, 40'h12_3456_78AB, 40'h24_68AC_F156, 181);
    check("dr_byp_edges", tms_log.size(), 45);
    check("dr_byp_tms", pack_tms(), 64'h0000_0C00_0000_0001);
    check("dr_byp_tdi", pack_tdi(3, 40), 64'h12_3456_78AB);

    run_cmd("idle3", 2'b11, 40'hFF_FFFF_FF03, '0, 13);
    check("idle3_edges", tms_log.size(), 3);
    check("idle3_tms", pack_tms(), 0);
    run_cmd("idle0", 2'b11, 40'hFF_FFFF_FF00, '0, 1);
    check("idle0_edges", tms_log.size(), 0);

    // Abort a DR scan during shift bit 20 (bit index 23, TCK high).
    @(negedge clk);
    tms_log.delete();
    tdi_log.delete();
    bus.cmd_valid = 1'b1;
    bus.cmd_type  = 2'b10;
    bus.cmd_data  = 40'hFF_FF00_0000;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < LIM; i++) begin
      if (tms_log.size() >= 24) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("abort_reach", hit, 1);
    check("abort_pre_tck", jtag_TCK, 1);
    n0 = rsp_cnt;
    rst = 1'b0;
    @(negedge clk);
    check("abort_tck", jtag_TCK, 0);
    check("abort_tms", jtag_TMS, 1);
    check("abort_tdi", jtag_TDI, 1);
    check("abort_ready", bus.cmd_ready, 1);
    check("abort_rsp_data", bus.rsp_data, 0);
    rst = 1'b1;
    repeat (60) @(negedge clk);
    check("abort_no_rsp", rsp_cnt - n0, 0);

    run_cmd("tlr2", 2'b00, '0, '0, 37);
    check("tlr2_tap", tap, RTI);

    // cmd_valid held high across two commands; a busy-time command change is ignored.
    @(negedge clk);
    tms_log.delete();
    n0 = rsp_cnt;
    bus.cmd_valid = 1'b1;
    bus.cmd_type  = 2'b11;
    bus.cmd_data  = 40'd2;
    @(posedge clk);
    exp_q.push_back('0);
    @(negedge clk);
    bus.cmd_type = 2'b10;
    bus.cmd_data = 40'hDE_ADBE_EF00;
    wait_rsp("b2b_first", 9);
    bus.cmd_type = 2'b11;
    bus.cmd_data = 40'd1;
    @(posedge clk);
    exp_q.push_back('0);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("b2b_accept2", bus.busy, 1);
    wait_rsp("b2b_second", 5);
    repeat (20) @(negedge clk);
    check("b2b_pulses", rsp_cnt - n0, 2);
    check("b2b_edges", tms_log.size(), 3);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
